// File: rtl/fx_add_arbiter.sv
// fx_add_arbiter: round-robin sharing of one sign-magnitude fixed-point adder
// between REQ requesters. The operands are registered at grant, the sum is
// registered one cycle later, and the sum is held until the consumer accepts it.
// Optional build macro: FX_ADD_ARB_SAT_EN (saturate to +/-max on magnitude overflow).
//
// state | meaning
// IDLE  | waiting for a request; req_ready_out grants combinationally
// CALC  | operands registered; sum and overflow registered on the next edge
// RESP  | rsp_valid_out asserted for id_q; sum held until rsp_ready_in
module fx_add_arbiter #(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter int REQ = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [REQ-1:0]     req_valid_in,
  output logic [REQ-1:0]     req_ready_out,
  input  logic [REQ*N-1:0]   summand_a_in,
  input  logic [REQ*N-1:0]   summand_b_in,
  output logic [REQ-1:0]     rsp_valid_out,
  input  logic               rsp_ready_in,
  output logic [N-1:0]       sum_out,
  output logic               ovf_out
);

  localparam int IDW = $clog2(REQ);

  // Q only describes where the binary point sits; the adder itself is
  // point-agnostic, so it just has to fit inside the magnitude field.
  if (Q >= N - 1) begin : g_bad_q
    $error("fx_add_arbiter: Q must be smaller than N-1");
  end
  if (REQ < 2 || REQ > 8) begin : g_bad_req
    $error("fx_add_arbiter: REQ must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   a_sel;
  logic [N-1:0]   b_sel;

  logic           sa;
  logic           sb;
  logic [N-2:0]   ma;
  logic [N-2:0]   mb;
  logic [N-1:0]   mag_sum;
  logic [N-2:0]   mag_res;
  logic           sign_res;
  logic           ovf_c;
  logic [N-1:0]   sum_c;

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 1; k <= REQ; k++) begin
      idx   = (int'(last) + k) % REQ;
      idx_w = IDW'(idx);
      if (!grant_found && req_valid_in[idx_w]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  // Operand mux for the requester being granted.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        a_sel = summand_a_in[i*N +: N];
        b_sel = summand_b_in[i*N +: N];
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is being applied.
  always_comb begin
    req_ready_out = '0;
    if (state == IDLE && !rst_in && grant_found) begin
      req_ready_out = REQ'(1) << grant_id;
    end
  end

  // Sign-magnitude add on the registered operands; subtraction ties give +0.
  always_comb begin
    sa       = a_q[N-1];
    sb       = b_q[N-1];
    ma       = a_q[N-2:0];
    mb       = b_q[N-2:0];
    mag_sum  = {1'b0, ma} + {1'b0, mb};
    mag_res  = '0;
    sign_res = 1'b0;
    ovf_c    = 1'b0;
    if (sa == sb) begin
      mag_res  = mag_sum[N-2:0];
      sign_res = sa;
      ovf_c    = mag_sum[N-1];
    end else if (ma > mb) begin
      mag_res  = ma - mb;
      sign_res = sa;
    end else if (mb > ma) begin
      mag_res  = mb - ma;
      sign_res = sb;
    end
`ifdef FX_ADD_ARB_SAT_EN
    if (ovf_c) begin
      mag_res = '1;
    end
`else
    // Wrapped result passes through; a negative wrap may read as -0.
`endif
    sum_c = {sign_res, mag_res};
  end

  // Controller FSM with registered response outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      last          <= IDW'(REQ - 1);
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sum_out       <= '0;
      ovf_out       <= 1'b0;
      rsp_valid_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_q   <= a_sel;
            b_q   <= b_sel;
            id_q  <= grant_id;
            last  <= grant_id;
            state <= CALC;
          end
        end
        CALC: begin
          sum_out       <= sum_c;
          ovf_out       <= ovf_c;
          rsp_valid_out <= REQ'(1) << id_q;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready_in) begin
            rsp_valid_out <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          rsp_valid_out <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_add_arbiter.sv
// Testbench for fx_add_arbiter (Q=15, N=32, REQ=4): directed vectors, expected
// responses queued at grant time and checked by an independent response monitor.
module tb_fx_add_arbiter;
  localparam int Q   = 15;
  localparam int N   = 32;
  localparam int REQ = 4;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [REQ-1:0]    req_valid_in = '0;
  logic [REQ-1:0]    req_ready_out;
  logic [REQ*N-1:0]  summand_a_in = '0;
  logic [REQ*N-1:0]  summand_b_in = '0;
  logic [REQ-1:0]    rsp_valid_out;
  logic              rsp_ready_in = 1'b1;
  logic [N-1:0]      sum_out;
  logic              ovf_out;

  fx_add_arbiter #(.Q(Q), .N(N), .REQ(REQ)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .summand_a_in  (summand_a_in),
    .summand_b_in  (summand_b_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .sum_out       (sum_out),
    .ovf_out       (ovf_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [3:0] oh(int i);
    oh = 4'b0001 << i;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Response monitor: every accepted response is matched against the queue head.
  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst_in && rsp_valid_out != '0 && rsp_ready_in) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid_out=%b, expected no response", rsp_valid_out);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_valid_out), 32'(oh(e.id)));
        chk("rsp_sum", sum_out, e.sum);
        chk("rsp_ovf", 32'(ovf_out), 32'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
    summand_a_in[i*N +: N] = a;
    summand_b_in[i*N +: N] = b;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
  endtask

  // Issue one request alone; check grant and grant-to-response latency.
  task automatic do_op(string nm, int i, logic [31:0] a, logic [31:0] b,
                       logic [31:0] s, logic o);
    int lat;
    set_req(i, a, b);
    req_valid_in = oh(i);
    @(negedge clk_in);
    chk({nm, "_grant"}, 32'(req_ready_out), 32'(oh(i)));
    sb_q.push_back('{id: i, sum: s, ovf: o});
    @(posedge clk_in); #1 req_valid_in = '0;
    lat = 1;
    @(negedge clk_in);
    while (rsp_valid_out == '0 && lat < 8) begin
      @(negedge clk_in);
      lat++;
    end
    chk({nm, "_latency"}, lat, 2);
    @(posedge clk_in); #1;
  endtask

  initial begin : stim
    int rr1[5];
    int rr2[3];
    rr1 = '{0, 1, 2, 3, 0};
    rr2 = '{1, 3, 1};

    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_req_ready", 32'(req_ready_out), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_out), 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_ovf", 32'(ovf_out), 0);
    @(posedge clk_in); #1;

    do_op("single",     0, 32'h0000_8000, 32'h8000_4000, 32'h0000_4000, 1'b0);
    do_op("cancel",     2, 32'h0000_8000, 32'h8000_8000, 32'h0000_0000, 1'b0);
    do_op("bigger_neg", 1, 32'h0000_4000, 32'h8000_C000, 32'h8000_8000, 1'b0);
    do_op("neg_neg",    3, 32'h8000_4000, 32'h8000_4000, 32'h8000_8000, 1'b0);
`ifdef FX_ADD_ARB_SAT_EN
    do_op("ovf_pos",    0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    do_op("ovf_neg",    1, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
`else
    do_op("ovf_pos",    0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    do_op("ovf_neg",    1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0000, 1'b1);
`endif

    // Round robin with all four requesting: requester i adds i.0 + 1.0.
    do_reset();
    for (int i = 0; i < REQ; i++) set_req(i, 32'(i) << 15, 32'h0000_8000);
    for (int k = 0; k < 5; k++)
      sb_q.push_back('{id: rr1[k], sum: 32'(rr1[k] + 1) << 15, ovf: 1'b0});
    req_valid_in = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk_in);
      chk("rr_all_grant", 32'(req_ready_out), (c % 3 == 0) ? 32'(oh(rr1[c/3])) : 32'd0);
    end
    @(posedge clk_in); #1 req_valid_in = '0;
    repeat (3) @(posedge clk_in);
    #1;

    // Round robin between requesters 1 and 3 only.
    do_reset();
    for (int k = 0; k < 3; k++)
      sb_q.push_back('{id: rr2[k], sum: 32'(rr2[k] + 1) << 15, ovf: 1'b0});
    req_valid_in = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_in);
      chk("rr_13_grant", 32'(req_ready_out), (c % 3 == 0) ? 32'(oh(rr2[c/3])) : 32'd0);
    end
    @(posedge clk_in); #1 req_valid_in = '0;
    repeat (3) @(posedge clk_in);
    #1;

    // Backpressure: response held five cycles while requester 0 waits.
    set_req(3, 32'h0000_8000, 32'h0000_8000);
    set_req(0, 32'h0000_8000, 32'h0000_0000);
    rsp_ready_in = 1'b0;
    req_valid_in = 4'b1000;
    @(negedge clk_in);
    chk("bp_grant", 32'(req_ready_out), 32'(4'b1000));
    sb_q.push_back('{id: 3, sum: 32'h0001_0000, ovf: 1'b0});
    @(posedge clk_in); #1 req_valid_in = 4'b0001;
    @(negedge clk_in);
    chk("bp_calc_rsp_valid", 32'(rsp_valid_out), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("bp_rsp_valid", 32'(rsp_valid_out), 32'(4'b1000));
      chk("bp_sum", sum_out, 32'h0001_0000);
      chk("bp_req_ready", 32'(req_ready_out), 0);
    end
    @(posedge clk_in); #1 rsp_ready_in = 1'b1;
    sb_q.push_back('{id: 0, sum: 32'h0000_8000, ovf: 1'b0});
    @(negedge clk_in);
    chk("bp_accept_req_ready", 32'(req_ready_out), 0);
    @(negedge clk_in);
    chk("bp_idle_grant", 32'(req_ready_out), 32'(4'b0001));
    @(posedge clk_in); #1 req_valid_in = '0;
    repeat (3) @(posedge clk_in);
    #1;

    // Reset while in CALC: result discarded, pointer back to requester 0 priority.
    set_req(0, 32'h0000_8000, 32'h0000_8000);
    req_valid_in = 4'b0001;
    @(negedge clk_in);
    chk("abort_grant", 32'(req_ready_out), 32'(4'b0001));
    @(posedge clk_in); #1 req_valid_in = '0; rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    set_req(1, 32'h0000_8000, 32'h0000_8000);
    set_req(2, 32'h0000_4000, 32'h0000_4000);
    req_valid_in = 4'b0110;
    @(negedge clk_in);
    chk("abort_rsp_valid", 32'(rsp_valid_out), 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_ovf", 32'(ovf_out), 0);
    chk("abort_next_grant", 32'(req_ready_out), 32'(4'b0010));
    sb_q.push_back('{id: 1, sum: 32'h0001_0000, ovf: 1'b0});
    @(posedge clk_in); #1 req_valid_in = '0;
    repeat (4) @(posedge clk_in);
    #1;

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
